// File: rtl/snow64_bfloat16_vector_cast_sequencer_if.sv
// Command, result and cast-unit signals of the BFloat16 vector cast
// sequencer, bundled so the execute stage and cast units share one port.
interface snow64_bfloat16_vector_cast_sequencer_if;
    logic         in_start;
    logic         in_dir;
    logic [1:0]   in_type_size;
    logic         in_type_signedness;
    logic [255:0] in_vec;
    logic         out_can_accept_cmd;
    logic         out_data_valid;
    logic [255:0] out_data;
    logic         out_from_int_start;
    logic         out_to_int_start;
    logic [63:0]  out_cast_to_cast;
    logic [1:0]   out_cast_type_size;
    logic         out_cast_type_signedness;
    logic         in_from_int_data_valid;
    logic         in_from_int_can_accept_cmd;
    logic [15:0]  in_from_int_data;
    logic         in_to_int_data_valid;
    logic         in_to_int_can_accept_cmd;
    logic [63:0]  in_to_int_data;

    modport slave (
        input  in_start, in_dir, in_type_size, in_type_signedness, in_vec,
        input  in_from_int_data_valid, in_from_int_can_accept_cmd,
        input  in_from_int_data,
        input  in_to_int_data_valid, in_to_int_can_accept_cmd, in_to_int_data,
        output out_can_accept_cmd, out_data_valid, out_data,
        output out_from_int_start, out_to_int_start, out_cast_to_cast,
        output out_cast_type_size, out_cast_type_signedness
    );

    modport master (
        output in_start, in_dir, in_type_size, in_type_signedness, in_vec,
        output in_from_int_data_valid, in_from_int_can_accept_cmd,
        output in_from_int_data,
        output in_to_int_data_valid, in_to_int_can_accept_cmd, in_to_int_data,
        input  out_can_accept_cmd, out_data_valid, out_data,
        input  out_from_int_start, out_to_int_start, out_cast_to_cast,
        input  out_cast_type_size, out_cast_type_signedness
    );
endinterface

// File: rtl/snow64_bfloat16_vector_cast_sequencer.sv
// Sequences scalar BFloat16 casts over a 256-bit vector, one lane at a
// time, and packs the per-lane results into a 256-bit result vector.
module snow64_bfloat16_vector_cast_sequencer (
    input  logic clk,
    input  logic rst_n,
    snow64_bfloat16_vector_cast_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ISSUED,
        ST_WAIT
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic         dir_q, dir_d;
    logic [1:0]   size_q, size_d;
    logic         sign_q, sign_d;
    logic [255:0] vec_q, vec_d;
    logic [255:0] acc_q, acc_d;
    logic         can_acc_q, can_acc_d;
    logic         valid_q, valid_d;
    logic         fi_start_q, fi_start_d;
    logic         ti_start_q, ti_start_d;
    logic [63:0]  opnd_q, opnd_d;

    logic         sel_can;
    logic         sel_valid;
    logic [3:0]   last_idx;

    function automatic logic [63:0] fetch(
        input logic [255:0] v,
        input logic         dir,
        input logic [1:0]   size,
        input logic [3:0]   lane
    );
        logic [63:0] e;
        e = '0;
        if (dir) begin
            e[15:0] = v[{lane, 4'b0} +: 16];
        end else begin
            unique case (size)
                2'd0: e[7:0]  = v[{1'b0, lane, 3'b0} +: 8];
                2'd1: e[15:0] = v[{lane, 4'b0} +: 16];
                2'd2: e[31:0] = v[{lane[2:0], 5'b0} +: 32];
                2'd3: e       = v[{lane[1:0], 6'b0} +: 64];
                default: e    = '0;
            endcase
        end
        return e;
    endfunction

    assign sel_can = dir_q ? bus.in_to_int_can_accept_cmd
                           : bus.in_from_int_can_accept_cmd;
    assign sel_valid = dir_q ? bus.in_to_int_data_valid
                             : bus.in_from_int_data_valid;

    always_comb begin
        last_idx = 4'd15;
        unique case (size_q)
            2'd2:    last_idx = 4'd7;
            2'd3:    last_idx = 4'd3;
            default: last_idx = 4'd15;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dir_d      = dir_q;
        size_d     = size_q;
        sign_d     = sign_q;
        vec_d      = vec_q;
        acc_d      = acc_q;
        can_acc_d  = can_acc_q;
        valid_d    = valid_q;
        fi_start_d = 1'b0;
        ti_start_d = 1'b0;
        opnd_d     = opnd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_start) begin
                    dir_d     = bus.in_dir;
                    size_d    = bus.in_type_size;
                    sign_d    = bus.in_type_signedness;
                    vec_d     = bus.in_vec;
                    idx_d     = '0;
                    acc_d     = '0;
                    valid_d   = 1'b0;
                    can_acc_d = 1'b0;
                    state_d   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (sel_can) begin
                    fi_start_d = !dir_q;
                    ti_start_d = dir_q;
                    opnd_d     = fetch(vec_q, dir_q, size_q, idx_q);
                    state_d    = ST_ISSUED;
                end
            end
            // The unit's data_valid may still be stale from the last lane.
            ST_ISSUED: state_d = ST_WAIT;
            ST_WAIT: begin
                if (sel_valid) begin
                    if (!dir_q) begin
                        acc_d[{idx_q, 4'b0} +: 16] = bus.in_from_int_data;
                    end else begin
                        unique case (size_q)
                            2'd0: acc_d[{1'b0, idx_q, 3'b0} +: 8] =
                                bus.in_to_int_data[7:0];
                            2'd1: acc_d[{idx_q, 4'b0} +: 16] =
                                bus.in_to_int_data[15:0];
                            2'd2: acc_d[{idx_q[2:0], 5'b0} +: 32] =
                                bus.in_to_int_data[31:0];
                            2'd3: acc_d[{idx_q[1:0], 6'b0} +: 64] =
                                bus.in_to_int_data;
                            default: acc_d = acc_q;
                        endcase
                    end
                    if (idx_q == last_idx) begin
                        valid_d   = 1'b1;
                        can_acc_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d      = idx_q + 4'd1;
                        fi_start_d = !dir_q;
                        ti_start_d = dir_q;
                        opnd_d     = fetch(vec_q, dir_q, size_q, idx_d);
                        state_d    = ST_ISSUED;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            dir_q      <= 1'b0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            vec_q      <= '0;
            acc_q      <= '0;
            can_acc_q  <= 1'b1;
            valid_q    <= 1'b0;
            fi_start_q <= 1'b0;
            ti_start_q <= 1'b0;
            opnd_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            vec_q      <= vec_d;
            acc_q      <= acc_d;
            can_acc_q  <= can_acc_d;
            valid_q    <= valid_d;
            fi_start_q <= fi_start_d;
            ti_start_q <= ti_start_d;
            opnd_q     <= opnd_d;
        end
    end

    assign bus.out_can_accept_cmd       = can_acc_q;
    assign bus.out_data_valid           = valid_q;
    assign bus.out_data                 = acc_q;
    assign bus.out_from_int_start       = fi_start_q;
    assign bus.out_to_int_start         = ti_start_q;
    assign bus.out_cast_to_cast         = opnd_q;
    assign bus.out_cast_type_size       = size_q;
    assign bus.out_cast_type_signedness = sign_q;
endmodule
